noc_traffic_gen: RTL and testbench
==================================

# noc_traffic_gen

Parametrised synthetic traffic generator for the BiNoC mesh. It is the successor to the fixed 3x3 mesh stimulus: one instance per router local port in an MESH_X x MESH_Y mesh. Each instance injects wormhole packets of PKT_LEN flits over a valid/ready flit handshake. It supports fixed, uniform-random and transpose destination modes, a programmable packet count and inter-packet gap, and cycle/flit/stall counters for throughput measurement.

## Interface
Parameters:
- MESH_X, 3, mesh columns (1..16)
- MESH_Y, 3, mesh rows (1..16)
- SRC_X, 0, this node's column
- SRC_Y, 0, this node's row
- FLIT_W, 32, flit width (>= 24)
- PKT_LEN, 4, flits per packet including head and tail (1..255)
- LFSR_SEED, 16'hACE1, random-mode seed (nonzero)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  generator enable
- start  in  1  one-cycle pulse that begins a run; sampled in IDLE and DONE only
- cfg_mode  in  2  0 fixed, 1 uniform random, 2 transpose, 3 reserved (treated as 0)
- cfg_dst_x / cfg_dst_y  in  4/4  destination in fixed mode
- cfg_num_pkts  in  16  packets per run; 0 means unlimited
- cfg_gap  in  8  idle cycles between tail acceptance and the next head
- flit_data  out  FLIT_W  flit
- flit_valid  out  1  flit present
- flit_ready  in  1  router accepts the flit
- busy  out  1  run in progress
- done  out  1  run complete
- pkt_cnt  out  16  packets whose tail has been accepted this run
- flit_cnt  out  32  flits accepted this run
- stall_cnt  out  32  cycles with valid && !ready; saturates at all-ones

## Operation
- Flit type field is [FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 single-flit (PKT_LEN=1).
- Head flit layout:
  - [15:12] src_x, [11:8] src_y, [7:4] dst_x, [3:0] dst_y
  - [FLIT_W-3:16] = sequence number (pkt_cnt) truncated
- Body and tail flit layout: [FLIT_W-3:8] = sequence number truncated, [7:0] = flit index (head is index 0).
- FSM states:
  - IDLE: start && enable → HEAD; clears all counters.
  - HEAD: on accept, PKT_LEN=1 → packet end; PKT_LEN=2 → TAIL; otherwise → BODY.
  - BODY: after PKT_LEN-2 body flits accepted → TAIL.
  - TAIL: on accept → packet end.
  - GAP: counts cfg_gap cycles, then → HEAD.
  - DONE: done=1; start && enable → HEAD with counters cleared; !enable → IDLE.
- Packet end, checked in this order:
  - pkt_cnt+1 == cfg_num_pkts (nonzero) → DONE.
  - !enable → IDLE.
  - cfg_gap == 0 → HEAD.
  - otherwise → GAP.
- enable deasserted mid-packet: the current packet completes. Packets are never truncated.
- Destination is latched when entering HEAD:
  - Fixed mode: cfg_dst.
  - Random mode: dst_x = lfsr[7:0] % MESH_X, dst_y = lfsr[15:8] % MESH_Y.
  - Transpose mode: dst = (SRC_Y, SRC_X); values outside the mesh are clamped to MESH-1.
  - A destination equal to the source node is legal.
- LFSR: Fibonacci, shifts left, feedback = l[15]^l[13]^l[12]^l[10]. Advances once per head acceptance.
- busy = state ∉ {IDLE, DONE}.

## Timing
- Reset values: all outputs 0, state IDLE, lfsr = LFSR_SEED.
- The head is valid in the cycle after start is sampled.
- A flit transfers on any edge where valid && ready. While stalled, flit_data and flit_valid are held stable.
- Back-to-back operation: with ready=1, a packet occupies exactly PKT_LEN cycles.
  - cfg_gap=0: the next head follows the tail with no bubble.
  - cfg_gap=G: exactly G cycles with valid=0 between tail and head.
- done rises the cycle after the final tail is accepted.
- Counters update on the accepting edge and are visible the following cycle.
- cfg_* are sampled continuously; changing them mid-run is allowed but unspecified beyond the next head.
- Reset asserted mid-packet: valid drops immediately (asynchronously). No partial packet resumes after reset.

## Test plan
- Fixed mode, SRC=(0,0), dst=(2,1), PKT_LEN=4, num_pkts=2, gap=0, ready=1 → 8 consecutive flits; head0 low 16 bits = 16'h0021; types 01,00,00,10 repeated; done asserted, pkt_cnt=2, flit_cnt=8.
- Same setup, ready held low 5 cycles on the second flit → flit_data stable across the stall, stall_cnt=5, flit_cnt=8.
- gap=3, num_pkts=3 → exactly 3 valid-low cycles between each tail and the next head; total run 12+6 cycles.
- Transpose mode, SRC=(1,2) → every head carries dst=(2,1). Random mode, 100 packets → all dst_x<3 and dst_y<3; the sequence matches a reference LFSR model.
- num_pkts=0, enable dropped during the third flit of packet 5 → packet 5 completes (tail seen), then IDLE with busy=0, done=0.
- rst pulled low during body flit 2 → all outputs 0 immediately; after release, start produces a head with sequence number 0 and lfsr=LFSR_SEED.

Source files
------------

// File: rtl/noc_traffic_gen.sv
// Synthetic wormhole traffic generator for one local port of a BiNoC mesh.
// Emits PKT_LEN-flit packets over a valid/ready handshake toward fixed,
// uniform-random or transpose destinations, and keeps run statistics.
module noc_traffic_gen #(
    parameter int          MESH_X    = 3,
    parameter int          MESH_Y    = 3,
    parameter int          SRC_X     = 0,
    parameter int          SRC_Y     = 0,
    parameter int          FLIT_W    = 32,
    parameter int          PKT_LEN   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic [1:0]        cfg_mode,
    input  logic [3:0]        cfg_dst_x,
    input  logic [3:0]        cfg_dst_y,
    input  logic [15:0]       cfg_num_pkts,
    input  logic [7:0]        cfg_gap,
    output logic [FLIT_W-1:0] flit_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_cnt,
    output logic [31:0]       flit_cnt,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_TAIL,
        S_GAP,
        S_DONE
    } state_e;

    // Sequence-number field widths in head and body/tail flits
    localparam int HSW = FLIT_W - 18;
    localparam int BSW = FLIT_W - 10;

    // Transpose destination, clamped into the mesh
    localparam logic [3:0] TR_X = (SRC_Y > MESH_X - 1) ? 4'(MESH_X - 1) : 4'(SRC_Y);
    localparam logic [3:0] TR_Y = (SRC_X > MESH_Y - 1) ? 4'(MESH_Y - 1) : 4'(SRC_X);

    state_e      state_q, state_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] flit_cnt_q, flit_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic [3:0]  dst_x_q, dst_x_d;
    logic [3:0]  dst_y_q, dst_y_d;
    logic [15:0] lfsr_q, lfsr_d;

    logic       accept;
    logic       pktEnd;
    logic       enterHead;
    logic       clearCnt;
    logic [3:0] selX;
    logic [3:0] selY;
    logic [HSW-1:0] seqHead;
    logic [BSW-1:0] seqBody;

    assign accept  = flit_valid && flit_ready;
    assign seqHead = HSW'(pkt_cnt_q);
    assign seqBody = BSW'(pkt_cnt_q);

    // Destination that will be latched the next time a head is entered
    always_comb begin
        selX = cfg_dst_x;
        selY = cfg_dst_y;
        case (cfg_mode)
            2'd1: begin
                selX = 4'(lfsr_q[7:0] % 8'(MESH_X));
                selY = 4'(lfsr_q[15:8] % 8'(MESH_Y));
            end
            2'd2: begin
                selX = TR_X;
                selY = TR_Y;
            end
            default: begin
                selX = cfg_dst_x;
                selY = cfg_dst_y;
            end
        endcase
    end

    // Next-state logic: packet sequencing, end-of-packet decision and counters
    always_comb begin
        state_d     = state_q;
        pkt_cnt_d   = pkt_cnt_q;
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        lfsr_d      = lfsr_q;
        pktEnd      = 1'b0;
        enterHead   = 1'b0;
        clearCnt    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && enable) begin
                    state_d   = S_HEAD;
                    enterHead = 1'b1;
                    clearCnt  = 1'b1;
                end
            end
            S_HEAD: begin
                if (accept) begin
                    idx_d  = 8'd1;
                    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    if (PKT_LEN == 1) begin
                        pktEnd = 1'b1;
                    end else if (PKT_LEN == 2) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (accept) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'(PKT_LEN - 2)) begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (accept) begin
                    pktEnd = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d   = S_HEAD;
                    enterHead = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_DONE: begin
                if (start && enable) begin
                    state_d   = S_HEAD;
                    enterHead = 1'b1;
                    clearCnt  = 1'b1;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pktEnd) begin
            if (cfg_num_pkts != 16'd0 && (pkt_cnt_q + 16'd1) == cfg_num_pkts) begin
                state_d = S_DONE;
            end else if (!enable) begin
                state_d = S_IDLE;
            end else if (cfg_gap == 8'd0) begin
                state_d   = S_HEAD;
                enterHead = 1'b1;
            end else begin
                state_d = S_GAP;
                gap_d   = cfg_gap - 8'd1;
            end
        end

        if (enterHead) begin
            dst_x_d = selX;
            dst_y_d = selY;
            idx_d   = 8'd0;
        end

        if (accept) begin
            flit_cnt_d = flit_cnt_q + 32'd1;
        end
        if (pktEnd) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (flit_valid && !flit_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end

        if (clearCnt) begin
            pkt_cnt_d   = '0;
            flit_cnt_d  = '0;
            stall_cnt_d = '0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pkt_cnt_q   <= '0;
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            flit_cnt_q  <= flit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // Flit formatting straight from registered state, so data holds while stalled
    always_comb begin
        flit_valid = 1'b0;
        flit_data  = '0;
        case (state_q)
            S_HEAD: begin
                flit_valid = 1'b1;
                flit_data  = {((PKT_LEN == 1) ? 2'b11 : 2'b01), seqHead,
                              4'(SRC_X), 4'(SRC_Y), dst_x_q, dst_y_q};
            end
            S_BODY: begin
                flit_valid = 1'b1;
                flit_data  = {2'b00, seqBody, idx_q};
            end
            S_TAIL: begin
                flit_valid = 1'b1;
                flit_data  = {2'b10, seqBody, idx_q};
            end
            default: begin
                flit_valid = 1'b0;
                flit_data  = '0;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign pkt_cnt   = pkt_cnt_q;
    assign flit_cnt  = flit_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Scoreboard bench for noc_traffic_gen at node (1,2) of a 3x3 mesh, 4-flit packets.
// Stimulus pushes hand-built expected flits; a monitor pops them on every transfer.
module tb_noc_traffic_gen;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        start;
    logic [1:0]  cfgMode;
    logic [3:0]  cfgDstX;
    logic [3:0]  cfgDstY;
    logic [15:0] cfgNumPkts;
    logic [7:0]  cfgGap;
    logic [31:0] flitData;
    logic        flitValid;
    logic        flitReady;
    logic        busy;
    logic        done;
    logic [15:0] pktCnt;
    logic [31:0] flitCnt;
    logic [31:0] stallCnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    logic        stallPrev = 1'b0;
    logic [31:0] stallData = '0;

    noc_traffic_gen #(
        .MESH_X(3), .MESH_Y(3), .SRC_X(1), .SRC_Y(2),
        .FLIT_W(32), .PKT_LEN(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .cfg_mode(cfgMode), .cfg_dst_x(cfgDstX), .cfg_dst_y(cfgDstY),
        .cfg_num_pkts(cfgNumPkts), .cfg_gap(cfgGap),
        .flit_data(flitData), .flit_valid(flitValid), .flit_ready(flitReady),
        .busy(busy), .done(done), .pkt_cnt(pktCnt), .flit_cnt(flitCnt),
        .stall_cnt(stallCnt)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] headFlit(input int seq, input logic [3:0] dx, input logic [3:0] dy);
        logic [15:0] s;
        s = seq[15:0];
        return {2'b01, s[13:0], 4'd1, 4'd2, dx, dy};
    endfunction

    function automatic logic [31:0] bodyFlit(input int seq, input logic [7:0] idx, input logic [1:0] typ);
        logic [15:0] s;
        s = seq[15:0];
        return {typ, 6'd0, s, idx};
    endfunction

    function automatic logic [15:0] lfsrNext(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic pushPacket(input int seq, input logic [3:0] dx, input logic [3:0] dy);
        expQ.push_back(headFlit(seq, dx, dy));
        expQ.push_back(bodyFlit(seq, 8'd1, 2'b00));
        expQ.push_back(bodyFlit(seq, 8'd2, 2'b00));
        expQ.push_back(bodyFlit(seq, 8'd3, 2'b10));
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] dx, input logic [3:0] dy,
                                 input logic [15:0] num, input logic [7:0] gap);
        cfgMode    = mode;
        cfgDstX    = dx;
        cfgDstY    = dy;
        cfgNumPkts = num;
        cfgGap     = gap;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Runs until done, counting busy cycles and checking every valid-low run length
    task automatic waitDone(input int maxCycles, input int expGap, output int busyCyc, output int lowCyc);
        int n;
        int run;
        n = 0;
        run = 0;
        busyCyc = 0;
        lowCyc = 0;
        while (!done && n < maxCycles) begin
            if (busy) busyCyc++;
            if (busy && !flitValid) begin
                lowCyc++;
                run++;
            end else if (flitValid && run > 0) begin
                checkOutput("gap_len", 32'(run), 32'(expGap));
                run = 0;
            end
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout got 0 expected 1 within %0d cycles", maxCycles);
        end
    endtask

    // Monitor: pop expected flit on every transfer and check stability while stalled
    always @(negedge clk) begin
        if (!rst) begin
            stallPrev <= 1'b0;
        end else begin
            if (stallPrev && flitValid) begin
                checkOutput("stall_hold", flitData, stallData);
            end
            if (flitValid && flitReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_flit got %h expected none", flitData);
                end else begin
                    checkOutput("flit", flitData, expQ.pop_front());
                end
            end
            stallPrev <= flitValid && !flitReady;
            stallData <= flitData;
        end
    end

    // Watchdog against a hung simulation
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bc;
        int lc;
        logic [15:0] l;

        rst        = 1'b0;
        enable     = 1'b0;
        start      = 1'b0;
        flitReady  = 1'b1;
        cfgMode    = 2'd0;
        cfgDstX    = 4'd0;
        cfgDstY    = 4'd0;
        cfgNumPkts = 16'd0;
        cfgGap     = 8'd0;
        repeat (3) tick();

        checkOutput("rst_valid", 32'(flitValid), 32'd0);
        checkOutput("rst_data", flitData, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pkt", 32'(pktCnt), 32'd0);
        checkOutput("rst_flit", flitCnt, 32'd0);
        checkOutput("rst_stall", stallCnt, 32'd0);
        rst    = 1'b1;
        enable = 1'b1;
        tick();

        $display("[TB] fixed mode, two packets back to back");
        pushPacket(0, 4'd2, 4'd1);
        pushPacket(1, 4'd2, 4'd1);
        applyStimulus(2'd0, 4'd2, 4'd1, 16'd2, 8'd0);
        checkOutput("head_valid", 32'(flitValid), 32'd1);
        waitDone(50, 0, bc, lc);
        checkOutput("fix_busy_cyc", 32'(bc), 32'd8);
        checkOutput("fix_low_cyc", 32'(lc), 32'd0);
        checkOutput("fix_done", 32'(done), 32'd1);
        checkOutput("fix_pkt", 32'(pktCnt), 32'd2);
        checkOutput("fix_flit", flitCnt, 32'd8);
        checkOutput("fix_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] stall five cycles on the second flit");
        pushPacket(0, 4'd2, 4'd1);
        pushPacket(1, 4'd2, 4'd1);
        applyStimulus(2'd0, 4'd2, 4'd1, 16'd2, 8'd0);
        tick();
        flitReady = 1'b0;
        repeat (5) tick();
        flitReady = 1'b1;
        waitDone(50, 0, bc, lc);
        checkOutput("stl_busy_cyc", 32'(bc), 32'd7);
        checkOutput("stl_stall", stallCnt, 32'd5);
        checkOutput("stl_flit", flitCnt, 32'd8);
        checkOutput("stl_pkt", 32'(pktCnt), 32'd2);
        checkOutput("stl_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] gap of three between three packets");
        pushPacket(0, 4'd0, 4'd2);
        pushPacket(1, 4'd0, 4'd2);
        pushPacket(2, 4'd0, 4'd2);
        applyStimulus(2'd0, 4'd0, 4'd2, 16'd3, 8'd3);
        waitDone(80, 3, bc, lc);
        checkOutput("gap_busy_cyc", 32'(bc), 32'd18);
        checkOutput("gap_low_cyc", 32'(lc), 32'd6);
        checkOutput("gap_pkt", 32'(pktCnt), 32'd3);
        checkOutput("gap_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] transpose mode");
        pushPacket(0, 4'd2, 4'd1);
        pushPacket(1, 4'd2, 4'd1);
        applyStimulus(2'd2, 4'd0, 4'd0, 16'd2, 8'd1);
        waitDone(50, 1, bc, lc);
        checkOutput("tr_busy_cyc", 32'(bc), 32'd9);
        checkOutput("tr_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] unlimited run, enable dropped in packet five");
        for (int p = 0; p < 5; p++) pushPacket(p, 4'd1, 4'd2);
        applyStimulus(2'd0, 4'd1, 4'd2, 16'd0, 8'd0);
        repeat (18) tick();
        enable = 1'b0;
        for (int n = 0; n < 20 && busy; n++) tick();
        checkOutput("en_busy", 32'(busy), 32'd0);
        checkOutput("en_done", 32'(done), 32'd0);
        checkOutput("en_pkt", 32'(pktCnt), 32'd5);
        checkOutput("en_flit", flitCnt, 32'd20);
        checkOutput("en_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] reset during second body flit");
        enable = 1'b1;
        pushPacket(0, 4'd2, 4'd1);
        pushPacket(1, 4'd2, 4'd1);
        applyStimulus(2'd0, 4'd2, 4'd1, 16'd2, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(flitValid), 32'd0);
        checkOutput("ar_data", flitData, 32'd0);
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_pkt", 32'(pktCnt), 32'd0);
        checkOutput("ar_flit", flitCnt, 32'd0);
        checkOutput("ar_sb_left", 32'(expQ.size()), 32'd6);
        expQ.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] random mode, one hundred packets from the seed");
        l = 16'hACE1;
        for (int p = 0; p < 100; p++) begin
            pushPacket(p, 4'(l[7:0] % 8'd3), 4'(l[15:8] % 8'd3));
            l = lfsrNext(l);
        end
        applyStimulus(2'd1, 4'd0, 4'd0, 16'd100, 8'd0);
        waitDone(600, 0, bc, lc);
        checkOutput("rnd_busy_cyc", 32'(bc), 32'd400);
        checkOutput("rnd_pkt", 32'(pktCnt), 32'd100);
        checkOutput("rnd_flit", flitCnt, 32'd400);
        checkOutput("rnd_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] reserved mode behaves as fixed");
        pushPacket(0, 4'd2, 4'd2);
        applyStimulus(2'd3, 4'd2, 4'd2, 16'd1, 8'd0);
        waitDone(20, 0, bc, lc);
        checkOutput("rsv_busy_cyc", 32'(bc), 32'd4);
        checkOutput("rsv_sb_empty", 32'(expQ.size()), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
